// File: rtl/mem_access_stage.sv
// MEM pipeline stage: load/store against an internal word-addressed RAM with a fixed latency.
// Optional misalignment trap is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int MEM_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        validM,
    input  logic        Regfile_weM,
    input  logic        DataMem_weM,
    input  logic [4:0]  writeRegAddrM,
    input  logic [1:0]  regSrc_muxM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    output logic        stallM,
    output logic        validW,
    output logic        Regfile_weW,
    output logic [4:0]  writeRegAddrW,
    output logic [1:0]  regSrc_muxW,
    output logic [31:0] aluOutW,
    output logic [31:0] readDataW,
    output logic        misalignW
);

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam bit MULTI_CYCLE = (MEM_LAT > 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_mem_req;
    logic              w_is_store;
    logic              w_is_load;
    logic              w_misalign;
    logic              w_long_req;
    logic              w_complete;
    logic              w_stall;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       r_mem [DEPTH_WORDS];

    assign w_is_store = DataMem_weM;
    // Store wins over a simultaneous load flag, so the load path sees only pure loads.
    assign w_is_load  = (regSrc_muxM == 2'b01) & ~DataMem_weM;
    assign w_mem_req  = validM & (DataMem_weM | (regSrc_muxM == 2'b01));
    assign w_idx      = aluOutM[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_mem_req & (aluOutM[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_long_req = w_mem_req & ~w_misalign & MULTI_CYCLE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_long_req) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_INIT;
                    w_stall     = 1'b1;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_stall   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign stallM = w_stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // RAM is deliberately left out of reset; only the write is blocked by rst.
    always_ff @(posedge clk) begin
        if (!rst && w_complete && validM && w_is_store && !w_misalign) begin
            r_mem[w_idx] <= writeDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validW        <= 1'b0;
            Regfile_weW   <= 1'b0;
            writeRegAddrW <= '0;
            regSrc_muxW   <= '0;
            aluOutW       <= '0;
            readDataW     <= '0;
            misalignW     <= 1'b0;
        end else if (w_complete) begin
            validW        <= validM;
            Regfile_weW   <= Regfile_weM & ~w_misalign;
            writeRegAddrW <= writeRegAddrM;
            regSrc_muxW   <= regSrc_muxM;
            aluOutW       <= aluOutM;
            readDataW     <= (validM && w_is_load && !w_misalign) ? r_mem[w_idx] : '0;
            misalignW     <= w_misalign;
        end else begin
            validW        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized ops against a word-array model.
// Honours MEM_ALIGN_CHECK_EN the same way as the design.
module tb_mem_access_stage;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, Regfile_weM, DataMem_weM;
    logic [4:0]  writeRegAddrM;
    logic [1:0]  regSrc_muxM;
    logic [31:0] aluOutM, writeDataM;

    logic        stallM, validW, Regfile_weW, misalignW;
    logic [4:0]  writeRegAddrW;
    logic [1:0]  regSrc_muxW;
    logic [31:0] aluOutW, readDataW;

    logic        l1_stallM, l1_validW, l1_Regfile_weW, l1_misalignW;
    logic [4:0]  l1_writeRegAddrW;
    logic [1:0]  l1_regSrc_muxW;
    logic [31:0] l1_aluOutW, l1_readDataW;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    int          known_list [$];

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .validM(validM), .Regfile_weM(Regfile_weM),
        .DataMem_weM(DataMem_weM), .writeRegAddrM(writeRegAddrM), .regSrc_muxM(regSrc_muxM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .stallM(stallM), .validW(validW),
        .Regfile_weW(Regfile_weW), .writeRegAddrW(writeRegAddrW), .regSrc_muxW(regSrc_muxW),
        .aluOutW(aluOutW), .readDataW(readDataW), .misalignW(misalignW)
    );

    mem_access_stage #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .validM(validM), .Regfile_weM(Regfile_weM),
        .DataMem_weM(DataMem_weM), .writeRegAddrM(writeRegAddrM), .regSrc_muxM(regSrc_muxM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .stallM(l1_stallM), .validW(l1_validW),
        .Regfile_weW(l1_Regfile_weW), .writeRegAddrW(l1_writeRegAddrW), .regSrc_muxW(l1_regSrc_muxW),
        .aluOutW(l1_aluOutW), .readDataW(l1_readDataW), .misalignW(l1_misalignW)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        validM = 1'b0; Regfile_weM = 1'b0; DataMem_weM = 1'b0;
        writeRegAddrM = '0; regSrc_muxM = '0; aluOutM = '0; writeDataM = '0;
    endtask

    // Presents one instruction, holds it for the expected latency and checks the W bundle.
    task automatic issue(input string tag, input bit v, input bit rfwe, input bit we,
                         input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit          is_mem, is_load, mis;
        int          stalls, idx;
        logic [31:0] exp_rd;
        @(negedge clk);
        validM = v; Regfile_weM = rfwe; DataMem_weM = we; writeRegAddrM = rd;
        regSrc_muxM = src; aluOutM = addr; writeDataM = wd;
        is_mem  = v && (we || src == 2'b01);
        is_load = v && src == 2'b01 && !we;
`ifdef MEM_ALIGN_CHECK_EN
        mis = is_mem && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        stalls = (is_mem && !mis) ? LAT - 1 : 0;
        idx    = int'(addr >> 2) % DEPTH;
        exp_rd = (is_load && !mis) ? model_mem[idx] : 32'h0;
        for (int c = 0; c < stalls; c++) begin
            #1 check({tag, "/stall"}, 32'(stallM), 32'd1);
            @(posedge clk);
            #1 check({tag, "/bubble"}, 32'(validW), 32'd0);
            @(negedge clk);
        end
        #1 check({tag, "/nostall"}, 32'(stallM), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "/validW"}, 32'(validW), 32'(v));
        check({tag, "/rfweW"}, 32'(Regfile_weW), 32'(rfwe && !mis));
        check({tag, "/rdW"}, 32'(writeRegAddrW), 32'(rd));
        check({tag, "/srcW"}, 32'(regSrc_muxW), 32'(src));
        check({tag, "/aluW"}, aluOutW, addr);
        check({tag, "/rdataW"}, readDataW, exp_rd);
        check({tag, "/misW"}, 32'(misalignW), 32'(mis));
        if (v && we && !mis) begin
            model_mem[idx] = wd;
            if (!known[idx]) begin
                known[idx] = 1'b1;
                known_list.push_back(idx);
            end
        end
    endtask

    initial begin
        logic [31:0] d [4];
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/validW", 32'(validW), 32'd0);
        check("rst/rfweW", 32'(Regfile_weW), 32'd0);
        check("rst/aluW", aluOutW, 32'h0);
        check("rst/rdataW", readDataW, 32'h0);
        check("rst/stallM", 32'(stallM), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a store must not commit it.
        issue("seed5", 1, 0, 1, 5'd0, 2'b00, 32'h14, 32'h11111111);
        @(negedge clk);
        validM = 1'b1; DataMem_weM = 1'b1; regSrc_muxM = 2'b00;
        aluOutM = 32'h14; writeDataM = 32'h22222222;
        #1 check("abort/stall", 32'(stallM), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort/validW", 32'(validW), 32'd0);
        check("abort/stallM", 32'(stallM), 32'd0);
        check("abort/aluW", aluOutW, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        issue("ld5", 1, 1, 0, 5'd9, 2'b01, 32'h14, 32'h0);

        issue("alu", 1, 1, 0, 5'd3, 2'b00, 32'h1234, 32'h0);
        issue("st10", 1, 0, 1, 5'd0, 2'b00, 32'h10, 32'hDEADBEEF);
        issue("ld10", 1, 1, 0, 5'd7, 2'b01, 32'h10, 32'h0);
        issue("stwrap", 1, 0, 1, 5'd0, 2'b00, DEPTH * 4 + 8, 32'hA5A5A5A5);
        issue("ldwrap", 1, 1, 0, 5'd4, 2'b01, 32'h8, 32'h0);
        issue("misst", 1, 1, 1, 5'd2, 2'b00, 32'h13, 32'hCAFEF00D);
        issue("ldafter", 1, 1, 0, 5'd6, 2'b01, 32'h10, 32'h0);
        issue("misld", 1, 1, 0, 5'd6, 2'b01, 32'h12, 32'h0);
        issue("ldst", 1, 1, 1, 5'd8, 2'b01, 32'h20, 32'h0BADF00D);
        issue("bubble", 0, 1, 1, 5'd1, 2'b01, 32'h24, 32'h5);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            logic [1:0]  lo;
            kind = int'($urandom_range(0, 4));
            lo   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            case (kind)
                0: issue("r_alu", 1, 1'($urandom), 0, 5'($urandom), ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00,
                         $urandom, $urandom);
                1: issue("r_bub", 0, 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom);
                2: begin
                    a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'(lo);
                    issue("r_st", 1, 0, 1, 5'd0, 2'b00, a, $urandom);
                end
                3: begin
                    if (known_list.size() > 0) begin
                        a = ($urandom & 32'hFFFF_F000)
                            | (32'(known_list[$urandom_range(0, known_list.size() - 1)]) << 2) | 32'(lo);
                        issue("r_ld", 1, 1, 0, 5'($urandom), 2'b01, a, 32'h0);
                    end else begin
                        issue("r_alu2", 1, 1, 0, 5'd1, 2'b00, $urandom, 32'h0);
                    end
                end
                default: begin
                    a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'(lo);
                    issue("r_ldst", 1, 1, 1, 5'($urandom), 2'b01, a, $urandom);
                end
            endcase
        end

        // Single-cycle instance: four stores then four loads, no stall at any point.
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            @(negedge clk);
            validM = 1'b1; Regfile_weM = 1'b0; DataMem_weM = 1'b1; regSrc_muxM = 2'b00;
            aluOutM = 32'((900 + i) * 4); writeDataM = d[i];
            #1 check("l1st/stall", 32'(l1_stallM), 32'd0);
            @(posedge clk);
            #1 check("l1st/validW", 32'(l1_validW), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            validM = 1'b1; Regfile_weM = 1'b1; DataMem_weM = 1'b0; regSrc_muxM = 2'b01;
            writeRegAddrM = 5'(i + 1); aluOutM = 32'((900 + i) * 4); writeDataM = '0;
            #1 check("l1ld/stall", 32'(l1_stallM), 32'd0);
            @(posedge clk);
            #1;
            check("l1ld/validW", 32'(l1_validW), 32'd1);
            check("l1ld/rdataW", l1_readDataW, d[i]);
            check("l1ld/rdW", 32'(l1_writeRegAddrW), 32'(i + 1));
        end
        @(negedge clk);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
